// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bus: pipeline-register outputs in, read ports and commit/forwarding info out.
interface wb_regfile_if;
    logic        MemtoReg_q;
    logic        RegWrite_q;
    logic [31:0] read_data_q;
    logic [31:0] ALU_result_q;
    logic [4:0]  rd_q;
    logic [5:0]  opcode_q;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    modport master (
        output MemtoReg_q, RegWrite_q, read_data_q, ALU_result_q, rd_q, opcode_q,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, wb_we, wb_addr, wb_data, wb_count
    );

    modport slave (
        input  MemtoReg_q, RegWrite_q, read_data_q, ALU_result_q, rd_q, opcode_q,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, wb_we, wb_addr, wb_data, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: load extraction, result mux, 32x32 register file with write-to-read bypass,
// and a retired-write counter.
module wb_regfile #(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter logic [31:0] SP_INIT    = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned SP_IDX = 29;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_wb_count;

    logic [1:0]      w_lane;
    logic            w_hlane;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_wb_data;
    logic            w_we;

    // Lane index counts from bit 0 upward; big-endian mirrors the byte offset.
    always_comb begin
        w_lane  = BIG_ENDIAN ? 2'(~bus.ALU_result_q[1:0]) : bus.ALU_result_q[1:0];
        w_hlane = BIG_ENDIAN ? ~bus.ALU_result_q[1] : bus.ALU_result_q[1];
        w_byte  = bus.read_data_q[7:0];
        case (w_lane)
            2'd0:    w_byte = bus.read_data_q[7:0];
            2'd1:    w_byte = bus.read_data_q[15:8];
            2'd2:    w_byte = bus.read_data_q[23:16];
            default: w_byte = bus.read_data_q[31:24];
        endcase
        w_half = w_hlane ? bus.read_data_q[31:16] : bus.read_data_q[15:0];
    end

    always_comb begin
        w_load = bus.read_data_q;
        case (bus.opcode_q)
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'd0, w_byte};
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'd0, w_half};
            default: w_load = bus.read_data_q;
        endcase
    end

    assign w_wb_data = bus.MemtoReg_q ? w_load : bus.ALU_result_q;
    assign w_we      = bus.RegWrite_q && (bus.rd_q != AW'(0)) && !reset;

    assign bus.wb_we    = w_we;
    assign bus.wb_addr  = bus.rd_q;
    assign bus.wb_data  = w_wb_data;
    assign bus.wb_count = r_wb_count;

    // r0 is never written since w_we excludes rd_q == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= (i == int'(SP_IDX)) ? SP_INIT : XLEN'(0);
            end
            r_wb_count <= XLEN'(0);
        end else if (w_we) begin
            r_regs[bus.rd_q] <= w_wb_data;
            r_wb_count       <= r_wb_count + XLEN'(1);
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == AW'(0))
            return XLEN'(0);
        else if (w_we && (addr == bus.rd_q))
            return w_wb_data;
        else
            return r_regs[addr];
    endfunction

    assign bus.rs_data = read_port(bus.rs_addr);
    assign bus.rt_data = read_port(bus.rt_addr);
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, ALU writes with bypass, r0, sub-word loads, bubbles,
// mid-stream reset and counter wrap.
module tb_wb_regfile;
    localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    wb_regfile_if bus ();

    wb_regfile #(.BIG_ENDIAN(1'b1), .SP_INIT(SP_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  ops  [12];
    logic [1:0]  offs [12];
    logic [31:0] exps [12];

    initial begin
        n_pass  = 0;
        n_total = 0;
        ops  = '{6'h20, 6'h24, 6'h20, 6'h21, 6'h25, 6'h23,
                 6'h20, 6'h24, 6'h21, 6'h21, 6'h25, 6'h0F};
        offs = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0,
                 2'd1, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
        exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_80FF,
                 32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_FFFF, 32'h0000_0001,
                 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_80FF, 32'h80FF_7F01};

        // Reset with a write pending: it must be dropped.
        reset            = 1'b1;
        bus.MemtoReg_q   = 1'b0;
        bus.RegWrite_q   = 1'b1;
        bus.read_data_q  = 32'h0;
        bus.ALU_result_q = 32'h0000_1234;
        bus.rd_q         = 5'd5;
        bus.opcode_q     = 6'h00;
        bus.rs_addr      = 5'd5;
        bus.rt_addr      = 5'd29;
        #1;
        check("we_in_reset", {31'd0, bus.wb_we}, 32'd0);
        step();
        step();
        reset          = 1'b0;
        bus.RegWrite_q = 1'b0;
        #1;
        check("reset_r5", bus.rs_data, 32'h0);
        check("reset_r29", bus.rt_data, SP_VAL);
        check("reset_count", bus.wb_count, 32'd0);
        bus.rs_addr = 5'd7;
        #1;
        check("reset_r7", bus.rs_data, 32'h0);

        // ALU write with same-cycle bypass on both ports.
        bus.RegWrite_q   = 1'b1;
        bus.rd_q         = 5'd8;
        bus.ALU_result_q = 32'hDEAD_BEEF;
        bus.rs_addr      = 5'd8;
        bus.rt_addr      = 5'd8;
        #1;
        check("alu_we", {31'd0, bus.wb_we}, 32'd1);
        check("alu_addr", {27'd0, bus.wb_addr}, 32'd8);
        check("alu_data", bus.wb_data, 32'hDEAD_BEEF);
        check("bypass_rs", bus.rs_data, 32'hDEAD_BEEF);
        check("bypass_rt", bus.rt_data, 32'hDEAD_BEEF);
        step();
        bus.RegWrite_q = 1'b0;
        #1;
        check("r8_committed", bus.rs_data, 32'hDEAD_BEEF);
        check("count_1", bus.wb_count, 32'd1);

        // r0 write is discarded.
        bus.RegWrite_q   = 1'b1;
        bus.rd_q         = 5'd0;
        bus.ALU_result_q = 32'hFFFF_FFFF;
        bus.rs_addr      = 5'd0;
        #1;
        check("r0_we", {31'd0, bus.wb_we}, 32'd0);
        check("r0_bypass", bus.rs_data, 32'h0);
        step();
        bus.RegWrite_q = 1'b0;
        #1;
        check("r0_read", bus.rs_data, 32'h0);
        check("r0_count", bus.wb_count, 32'd1);

        // Sub-word loads into r10..r21.
        bus.MemtoReg_q  = 1'b1;
        bus.read_data_q = 32'h80FF_7F01;
        for (int i = 0; i < 12; i++) begin
            bus.RegWrite_q   = 1'b1;
            bus.rd_q         = 5'(10 + i);
            bus.opcode_q     = ops[i];
            bus.ALU_result_q = {30'h0400_0000, offs[i]};
            #1;
            check($sformatf("load_%0d_op%h_a%0d", i, ops[i], offs[i]), bus.wb_data, exps[i]);
            step();
        end
        bus.RegWrite_q = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.rs_addr = 5'(10 + i);
            #1;
            check($sformatf("load_readback_r%0d", 10 + i), bus.rs_data, exps[i]);
        end
        check("count_13", bus.wb_count, 32'd13);

        // Bubble: no bypass, no state change.
        bus.MemtoReg_q   = 1'b0;
        bus.RegWrite_q   = 1'b0;
        bus.rd_q         = 5'd8;
        bus.ALU_result_q = 32'h1111_2222;
        bus.rs_addr      = 5'd8;
        #1;
        check("bubble_no_bypass", bus.rs_data, 32'hDEAD_BEEF);
        step();
        check("bubble_r8", bus.rs_data, 32'hDEAD_BEEF);
        check("bubble_count", bus.wb_count, 32'd13);

        // A normal write to r29 overrides the reset value.
        bus.RegWrite_q   = 1'b1;
        bus.rd_q         = 5'd29;
        bus.ALU_result_q = 32'hCAFE_F00D;
        step();
        bus.RegWrite_q = 1'b0;
        bus.rt_addr    = 5'd29;
        #1;
        check("r29_override", bus.rt_data, 32'hCAFE_F00D);

        // Mid-stream reset drops the concurrent write.
        reset            = 1'b1;
        bus.RegWrite_q   = 1'b1;
        bus.rd_q         = 5'd8;
        bus.ALU_result_q = 32'h5555_AAAA;
        #1;
        check("mid_reset_we", {31'd0, bus.wb_we}, 32'd0);
        check("mid_reset_no_bypass", bus.rs_data, 32'hDEAD_BEEF);
        step();
        reset          = 1'b0;
        bus.RegWrite_q = 1'b0;
        #1;
        check("mid_reset_r8", bus.rs_data, 32'h0);
        check("mid_reset_r29", bus.rt_data, SP_VAL);
        check("mid_reset_count", bus.wb_count, 32'd0);

        // Counter wrap from all-ones.
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        #1;
        check("count_preset", bus.wb_count, 32'hFFFF_FFFF);
        bus.RegWrite_q   = 1'b1;
        bus.rd_q         = 5'd3;
        bus.ALU_result_q = 32'h0000_0042;
        step();
        bus.RegWrite_q = 1'b0;
        bus.rs_addr    = 5'd3;
        #1;
        check("count_wrap", bus.wb_count, 32'd0);
        check("wrap_r3", bus.rs_data, 32'h0000_0042);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the pipelined MIPS core, sitting on the consuming side of the MEM/WB pipeline register. It selects memory or ALU data, applies load byte/halfword extraction by opcode, and commits the result to a 32×32 register file. It serves the decode stage's two combinational read ports, with same-cycle write-to-read bypass. It also exposes the committed write for the forwarding unit and keeps a retired-write counter.

## Interface
- BIG_ENDIAN, 1, byte lane order for sub-word loads: 1 = byte offset 0 is bits 31:24; 0 = byte offset 0 is bits 7:0.
- SP_INIT, 32'h0000_0000, value loaded into register 29 on reset.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemtoReg_q  in  1  from MEM/WB: 1 = write load data, 0 = write ALU result.
- RegWrite_q  in  1  from MEM/WB: write enable; 0 = bubble.
- read_data_q  in  32  raw memory word from MEM/WB.
- ALU_result_q  in  32  ALU result, or effective address for loads.
- rd_q  in  5  destination register.
- opcode_q  in  6  instruction opcode, used for load extraction.
- rs_addr, rt_addr  in  5 each  decode-stage read addresses.
- rs_data, rt_data  out  32 each  combinational read data.
- wb_we  out  1  effective write this cycle: RegWrite_q && rd_q != 0 && !reset.
- wb_addr  out  5  equals rd_q.
- wb_data  out  32  final writeback value, after the mux and extraction.
- wb_count  out  32  registered count of effective writes.

## Operation
- **Writeback mux.**
  - MemtoReg_q=0: wb_data = ALU_result_q.
  - MemtoReg_q=1: wb_data = extract(read_data_q, opcode_q, ALU_result_q[1:0]).
- **Extraction.** a = ALU_result_q[1:0].
  - 6'h20 lb: select byte a, sign-extend.
  - 6'h24 lbu: select byte a, zero-extend.
  - 6'h21 lh: select halfword a[1], sign-extend; a[0] is ignored.
  - 6'h25 lhu: select halfword a[1], zero-extend.
  - 6'h23 lw, and any other opcode: full word unchanged.
  - Big-endian selection: byte 0 = [31:24], byte 3 = [7:0], half 0 = [31:16].
  - Little-endian selection: the mirror image.
- **Write.** On a rising edge with wb_we=1, regs[rd_q] <= wb_data.
- **Register 0.** Always reads 0. A write to r0 is discarded and does not count.
- **Reads.** Combinational.
  - If wb_we=1 and the address equals rd_q, the port returns wb_data (bypass).
  - Otherwise it returns regs[addr].
  - Address 0 returns 0 regardless of the bypass.
- **Counter.** wb_count increments by 1 on each edge with wb_we=1. It wraps from 32'hFFFF_FFFF to 0.
- **Reset.** While reset=1 at an edge:
  - all registers clear to 0, except regs[29] <= SP_INIT;
  - wb_count <= 0;
  - any concurrent write is dropped and not counted;
  - wb_we is 0 during reset.
- No internal state machine beyond the register array and counter. Bubbles (RegWrite_q=0) leave all state unchanged.

## Timing
- Write latency: a write is committed at the edge ending the cycle in which it is presented. It is visible the same cycle via bypass, and from regs the next cycle.
- Read latency: 0 cycles (combinational, address to data).
- wb_we, wb_addr and wb_data are combinational from the MEM/WB outputs. They are valid in the same cycle, for the forwarding unit.
- Reset values after the first reset edge:
  - every register 0, except r29 = SP_INIT;
  - rs_data and rt_data read 0 for all addresses except 29;
  - wb_count = 0.
- Reset mid-stream: the instruction presented in the reset cycle is lost. Operation resumes on the first edge with reset=0.
- Simultaneous events:
  - Both read ports may hit the write address in one cycle; both are bypassed.
  - A write to r29 in a non-reset cycle overrides SP_INIT.

## Test plan
- **Reset.** Assert reset with RegWrite_q=1, rd_q=5, ALU_result_q=32'h1234 -> r5 reads 0, r29 reads SP_INIT, wb_count=0.
- **ALU write and bypass.** MemtoReg_q=0, RegWrite_q=1, rd_q=8, ALU_result_q=32'hDEAD_BEEF, rs_addr=8 -> rs_data=32'hDEAD_BEEF in the same cycle; r8 holds it next cycle; wb_count=1.
- **r0 discard.** RegWrite_q=1, rd_q=0, data 32'hFFFF_FFFF -> wb_we=0, rs_addr=0 reads 0, wb_count unchanged.
- **Sub-word loads (BIG_ENDIAN=1).** read_data_q=32'h80FF_7F01:
  - lb a=0 -> 32'hFFFF_FF80;
  - lbu a=0 -> 32'h0000_0080;
  - lb a=2 -> 32'h0000_007F;
  - lh a=0 -> 32'hFFFF_80FF;
  - lhu a=2 -> 32'h0000_7F01;
  - lw -> 32'h80FF_7F01.
- **Bubble.** RegWrite_q=0 with rd_q=8 and new data -> r8 unchanged, no bypass, wb_count unchanged.
- **Counter wrap.** Force wb_count to 32'hFFFF_FFFF, then one valid write -> wb_count=0.
